// File: rtl/fp_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_adder_pkg
//  Description : Shared binary32 definitions for the FP add unit: field
//                widths, rounding-mode encodings and canonical bit patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_adder_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Rounding-mode encodings on the rm input
    localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
    localparam logic [1:0] RM_RDN = 2'b01;  // toward -inf
    localparam logic [1:0] RM_RUP = 2'b10;  // toward +inf
    localparam logic [1:0] RM_RTZ = 2'b11;  // toward zero

    // Canonical patterns (magnitudes exclude the sign bit)
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG    = 31'h7F80_0000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic is_nan(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.frac != '0);
    endfunction

    function automatic logic is_inf(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.frac == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc24.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc24
//  Description : 24-bit leading-zero counter used to normalise the adder
//                significand. An all-zero input reports 24.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc24 (
    input  logic [23:0] i_d,
    output logic [4:0]  o_cnt
);

    logic [4:0] w_cnt;

    // Scan upward so the highest set bit is the last (winning) assignment
    always_comb begin
        w_cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_d[i]) begin
                w_cnt = 5'(23 - i);
            end
        end
    end

    assign o_cnt = w_cnt;

endmodule
`default_nettype wire

// File: rtl/fp_adder.sv
`default_nettype none
// ============================================================================
//  Module      : fp_adder
//  Description : binary32 adder/subtractor with four rounding modes. The
//                result is computed combinationally and registered, giving
//                one cycle of latency and one operation per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_adder
    import fp_adder_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic [1:0]  rm,
    output logic [31:0] s
);

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    fp32_t w_a;
    fp32_t w_b;
    logic  w_sa;
    logic  w_sb;
    logic  w_a_nan;
    logic  w_b_nan;
    logic  w_a_inf;
    logic  w_b_inf;

    assign w_a     = a;
    assign w_b     = b;
    assign w_sa    = w_a.sign;
    assign w_sb    = w_b.sign ^ sub;
    assign w_a_nan = is_nan(w_a);
    assign w_b_nan = is_nan(w_b);
    assign w_a_inf = is_inf(w_a);
    assign w_b_inf = is_inf(w_b);

    // ------------------------------------------------------------------
    // Swap so the larger magnitude is the "large" operand. Exponent and
    // fraction are contiguous, so a single 31-bit compare orders them.
    // ------------------------------------------------------------------
    logic        w_swap;
    logic        w_sl;
    logic        w_ss;
    logic [7:0]  w_el_raw;
    logic [7:0]  w_es_raw;
    logic [22:0] w_fl;
    logic [22:0] w_fs;
    logic [7:0]  w_el;
    logic [7:0]  w_es;
    logic [23:0] w_ml;
    logic [23:0] w_ms;

    assign w_swap   = (b[30:0] > a[30:0]);
    assign w_sl     = w_swap ? w_sb      : w_sa;
    assign w_ss     = w_swap ? w_sa      : w_sb;
    assign w_el_raw = w_swap ? w_b.exp   : w_a.exp;
    assign w_es_raw = w_swap ? w_a.exp   : w_b.exp;
    assign w_fl     = w_swap ? w_b.frac  : w_a.frac;
    assign w_fs     = w_swap ? w_a.frac  : w_b.frac;

    // Subnormals carry a zero hidden bit and behave as exponent 1
    assign w_el = (w_el_raw == 8'd0) ? 8'd1 : w_el_raw;
    assign w_es = (w_es_raw == 8'd0) ? 8'd1 : w_es_raw;
    assign w_ml = {(w_el_raw != 8'd0), w_fl};
    assign w_ms = {(w_es_raw != 8'd0), w_fs};

    // ------------------------------------------------------------------
    // Alignment: significand + guard + round + sticky (27 bits)
    // ------------------------------------------------------------------
    logic [7:0]  w_diff;
    logic [49:0] w_ext;
    logic [26:0] w_al_l;
    logic [26:0] w_al_s;

    assign w_diff = w_el - w_es;
    // Top 26 bits are significand, guard and round; the rest folds to sticky
    assign w_ext  = {w_ms, 26'd0} >> w_diff;
    assign w_al_l = {w_ml, 3'b000};
    assign w_al_s = (w_diff >= 8'd27) ? {26'd0, |w_ms}
                                      : {w_ext[49:24], |w_ext[23:0]};

    // ------------------------------------------------------------------
    // Significand add/subtract. The large operand is never smaller than
    // the small one, so subtraction cannot go negative.
    // ------------------------------------------------------------------
    logic        w_esub;
    logic [27:0] w_sum;

    assign w_esub = w_sl ^ w_ss;
    assign w_sum  = w_esub ? ({1'b0, w_al_l} - {1'b0, w_al_s})
                           : ({1'b0, w_al_l} + {1'b0, w_al_s});

    // ------------------------------------------------------------------
    // Normalisation
    // ------------------------------------------------------------------
    logic [4:0]  w_lz;
    logic [7:0]  w_lim;
    logic [7:0]  w_shamt;
    logic [26:0] w_nsh;
    logic [23:0] w_sig;
    logic        w_g;
    logic        w_rs;
    logic [8:0]  w_exp9;
    logic [8:0]  w_efield;

    fp_lzc24 u_lzc (
        .i_d   (w_sum[26:3]),
        .o_cnt (w_lz)
    );

    // Left shift may not take the exponent below 1; what remains is subnormal
    assign w_lim   = w_el - 8'd1;
    assign w_shamt = ({3'b000, w_lz} > w_lim) ? w_lim : {3'b000, w_lz};
    assign w_nsh   = w_sum[26:0] << w_shamt;

    // Pick the carry-out right shift or the limited left shift
    always_comb begin
        w_sig  = w_nsh[26:3];
        w_g    = w_nsh[2];
        w_rs   = |w_nsh[1:0];
        w_exp9 = {1'b0, w_el - w_shamt};
        if (w_sum[27]) begin
            w_sig  = w_sum[27:4];
            w_g    = w_sum[3];
            w_rs   = |w_sum[2:0];
            w_exp9 = {1'b0, w_el} + 9'd1;
        end
    end

    // A significand without its hidden bit is encoded with exponent 0
    assign w_efield = w_sig[23] ? w_exp9 : 9'd0;

    // ------------------------------------------------------------------
    // Rounding. The increment is added across {exponent, fraction} so a
    // fraction carry bumps the exponent, including subnormal -> normal.
    // ------------------------------------------------------------------
    logic        w_inc;
    logic [31:0] w_rnd;
    logic        w_ovf;

    // Rounding-increment decision per mode
    always_comb begin
        w_inc = 1'b0;
        case (rm)
            RM_RNE:  w_inc = w_g & (w_rs | w_sig[0]);
            RM_RDN:  w_inc =  w_sl & (w_g | w_rs);
            RM_RUP:  w_inc = ~w_sl & (w_g | w_rs);
            default: w_inc = 1'b0;
        endcase
    end

    assign w_rnd = {w_efield, w_sig[22:0]} + {31'd0, w_inc};
    assign w_ovf = (w_rnd[31:23] >= 9'd255);

    // ------------------------------------------------------------------
    // Result selection: specials, exact zero, overflow, ordinary
    // ------------------------------------------------------------------
    logic [31:0] w_res;

    // Final result priority: NaN, infinities, zero, overflow, normal
    always_comb begin
        w_res = {w_sl, w_rnd[30:0]};
        if (w_a_nan || w_b_nan) begin
            w_res = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_res = (w_sa != w_sb) ? QNAN : {w_sa, INF_MAG};
        end else if (w_a_inf) begin
            w_res = {w_sa, INF_MAG};
        end else if (w_b_inf) begin
            w_res = {w_sb, INF_MAG};
        end else if (w_sum == 28'd0) begin
            // Cancellation gives +0 except when rounding toward -inf
            w_res = {(w_esub ? (rm == RM_RDN) : w_sl), 31'd0};
        end else if (w_ovf) begin
            case (rm)
                RM_RNE:  w_res = {w_sl, INF_MAG};
                RM_RDN:  w_res = w_sl ? {1'b1, INF_MAG} : {1'b0, MAX_FINITE};
                RM_RUP:  w_res = w_sl ? {1'b1, MAX_FINITE} : {1'b0, INF_MAG};
                default: w_res = {w_sl, MAX_FINITE};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [31:0] r_s;

    // Capture the result each cycle; clrn clears it immediately
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_s <= 32'h0000_0000;
        end else begin
            r_s <= w_res;
        end
    end

    assign s = r_s;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_adder
//  Description : Scoreboard bench for fp_adder. Stimulus pushes the expected
//                result when it drives an operation; a monitor pops and
//                compares one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_adder;

    logic        clk;
    logic        clrn;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [1:0]  rm;
    logic [31:0] s;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    int          id_q[$];

    fp_adder dut (
        .clk  (clk),
        .clrn (clrn),
        .a    (a),
        .b    (b),
        .sub  (sub),
        .rm   (rm),
        .s    (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation (called just after a falling edge) and record
    // the value s must show after the next rising edge
    task automatic issue(input int id, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic [1:0] irm, input logic [31:0] iexp);
        a   = ia;
        b   = ib;
        sub = isub;
        rm  = irm;
        exp_q.push_back(iexp);
        id_q.push_back(id);
    endtask

    task automatic check_now(input string name, input logic [31:0] want);
        total++;
        if (s !== want) begin
            bad++;
            $display("FAIL %s: s=%08h expected=%08h", name, s, want);
        end
    endtask

    // Monitor: whatever was issued before this rising edge is checked now
    initial begin
        forever begin
            int n;
            @(posedge clk);
            n = exp_q.size();
            #1;
            if (n > 0) begin
                logic [31:0] want;
                int          id;
                want = exp_q.pop_front();
                id   = id_q.pop_front();
                total++;
                if (s !== want) begin
                    bad++;
                    $display("FAIL vec%0d: s=%08h expected=%08h", id, s, want);
                end
            end
        end
    end

    // Directed vectors: {a, b, sub, rm, expected}
    typedef struct packed {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vsub;
        logic [1:0]  vrm;
        logic [31:0] vexp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = {32'h440E11EC, 32'h4311C7AE, 1'b1, 2'b00, 32'h43D34001};
        vecs[1]  = {32'h440E11EC, 32'h4311C7AE, 1'b1, 2'b01, 32'h43D34001};
        vecs[2]  = {32'h440E11EC, 32'h4311C7AE, 1'b1, 2'b10, 32'h43D34001};
        vecs[3]  = {32'h440E11EC, 32'h4311C7AE, 1'b1, 2'b11, 32'h43D34001};
        vecs[4]  = {32'h440E11EC, 32'h4311C7AE, 1'b0, 2'b00, 32'h443283D8};
        vecs[5]  = {32'h440E11EC, 32'h4311C7AE, 1'b0, 2'b01, 32'h443283D7};
        vecs[6]  = {32'h440E11EC, 32'h4311C7AE, 1'b0, 2'b10, 32'h443283D8};
        vecs[7]  = {32'h440E11EC, 32'h4311C7AE, 1'b0, 2'b11, 32'h443283D7};
        vecs[8]  = {32'h41074BC7, 32'h41AE3D71, 1'b1, 2'b00, 32'hC1552F1B};
        vecs[9]  = {32'h41074BC7, 32'h41AE3D71, 1'b1, 2'b01, 32'hC1552F1B};
        vecs[10] = {32'h41074BC7, 32'h41AE3D71, 1'b1, 2'b10, 32'hC1552F1B};
        vecs[11] = {32'h41074BC7, 32'h41AE3D71, 1'b1, 2'b11, 32'hC1552F1B};
        vecs[12] = {32'h41074BC7, 32'h41AE3D71, 1'b0, 2'b00, 32'h41F1E354};
        vecs[13] = {32'h41074BC7, 32'h41AE3D71, 1'b0, 2'b01, 32'h41F1E354};
        vecs[14] = {32'h41074BC7, 32'h41AE3D71, 1'b0, 2'b10, 32'h41F1E355};
        vecs[15] = {32'h41074BC7, 32'h41AE3D71, 1'b0, 2'b11, 32'h41F1E354};
        vecs[16] = {32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000};
        vecs[17] = {32'h3F800000, 32'h3F800000, 1'b1, 2'b01, 32'h80000000};
        vecs[18] = {32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000};
        vecs[19] = {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000};
        vecs[20] = {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b11, 32'h7F7FFFFF};
        vecs[21] = {32'h00000001, 32'h00000001, 1'b0, 2'b00, 32'h00000002};
    end

    // Wait (bounded) for the monitor to consume every outstanding entry
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_%s: pending=%0d expected=0", tag, exp_q.size());
            exp_q.delete();
            id_q.delete();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clrn  = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        sub   = 1'b0;
        rm    = 2'b00;

        #2;
        check_now("reset_state", 32'h0000_0000);
        repeat (2) @(negedge clk);
        check_now("reset_hold", 32'h0000_0000);
        clrn = 1'b1;

        // Back-to-back directed operations, one per cycle
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            issue(i, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vrm, vecs[i].vexp);
        end
        drain("vectors");

        // Reset asserted mid-stream, between edges
        @(negedge clk);
        issue(100, 32'h440E11EC, 32'h4311C7AE, 1'b1, 2'b00, 32'h43D34001);
        drain("pre_reset");
        #2;
        clrn = 1'b0;
        #1;
        check_now("async_reset", 32'h0000_0000);
        @(posedge clk);
        #1;
        check_now("reset_low_edge", 32'h0000_0000);
        @(negedge clk);
        check_now("reset_low_hold", 32'h0000_0000);
        clrn = 1'b1;
        exp_q.push_back(32'h43D34001);
        id_q.push_back(101);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
